// File: rtl/async_fifo.sv
// Show-ahead FIFO, 2^ASIZE x DSIZE, one clock, wrap-bit pointers for full/empty.
// Define ASYNC_FIFO_COUNT_EN to add the O_count occupancy output.
module async_fifo #(
    parameter int ASIZE = 10,
    parameter int DSIZE = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_winc,
    input  logic [DSIZE-1:0] I_wdata,
    output logic             O_wfull,
    input  logic             I_rinc,
    output logic [DSIZE-1:0] O_rdata,
`ifdef ASYNC_FIFO_COUNT_EN
    output logic [ASIZE:0]   O_count,
`endif
    output logic             O_rempty
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] PTR_ONE = 1;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             wr_en;
    logic             rd_en;

    // Same low bits with opposite wrap bits means the writer is a full lap ahead.
    assign O_rempty = (wptr == rptr);
    assign O_wfull  = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);

    assign wr_en = I_winc && !O_wfull;
    assign rd_en = I_rinc && !O_rempty;

    // Storage is deliberately left out of reset; stale words are hidden by the pointers.
    always_ff @(posedge I_clk) begin
        if (wr_en) begin
            mem[wptr[ASIZE-1:0]] <= I_wdata;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wptr <= '0;
        end else if (wr_en) begin
            wptr <= wptr + PTR_ONE;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rptr <= '0;
        end else if (rd_en) begin
            rptr <= rptr + PTR_ONE;
        end
    end

    assign O_rdata = O_rempty ? '0 : mem[rptr[ASIZE-1:0]];

`ifdef ASYNC_FIFO_COUNT_EN
    assign O_count = wptr - rptr;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a queue model tracks accepted writes and a
// negedge monitor compares flags and head data every cycle; directed checks add hand values.
module tb_async_fifo;

    localparam int ASIZE = 10;
    localparam int DSIZE = 8;
    localparam int DEPTH = 1 << ASIZE;

    logic             clk;
    logic             rst_n;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
`ifdef ASYNC_FIFO_COUNT_EN
    logic [ASIZE:0]   count;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [DSIZE-1:0] exp_q [$];

    async_fifo #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .I_clk    (clk),
        .I_rst_n  (rst_n),
        .I_winc   (winc),
        .I_wdata  (wdata),
        .O_wfull  (wfull),
        .I_rinc   (rinc),
        .O_rdata  (rdata),
`ifdef ASYNC_FIFO_COUNT_EN
        .O_count  (count),
`endif
        .O_rempty (rempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 1 ns after the rising edge so the edge sees last cycle's values.
    task automatic applyStimulus(input logic w, input logic r, input logic [DSIZE-1:0] d);
        @(posedge clk);
        #1;
        winc  = w;
        rinc  = r;
        wdata = d;
    endtask

    // Behavioural model: pushes on accepted writes, pops on accepted reads.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            automatic bit rd_ok = rinc && (exp_q.size() > 0);
            automatic bit wr_ok = winc && (exp_q.size() < DEPTH);
            if (rd_ok) void'(exp_q.pop_front());
            if (wr_ok) exp_q.push_back(wdata);
        end
    end

    // Monitor: compares the presented head word and flags against the model.
    always @(negedge clk) begin
        checkOutput("mon_rempty", {31'd0, rempty}, {31'd0, exp_q.size() == 0});
        checkOutput("mon_wfull", {31'd0, wfull}, {31'd0, exp_q.size() == DEPTH});
        if (exp_q.size() > 0) begin
            checkOutput("mon_rdata", {24'd0, rdata}, {24'd0, exp_q[0]});
        end else begin
            checkOutput("mon_rdata_empty", {24'd0, rdata}, 32'd0);
        end
`ifdef ASYNC_FIFO_COUNT_EN
        checkOutput("mon_count", {21'd0, count}, exp_q.size());
`endif
    end

    initial begin
        logic [31:0] v;
        rst_n = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;

        // Reset held for three cycles, flags checked during and after.
        #1;
        checkOutput("rst_rempty", {31'd0, rempty}, 32'd1);
        checkOutput("rst_wfull", {31'd0, wfull}, 32'd0);
        checkOutput("rst_rdata", {24'd0, rdata}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, 0, 8'h00);
        checkOutput("post_rst_rempty", {31'd0, rempty}, 32'd1);
        checkOutput("post_rst_rdata", {24'd0, rdata}, 32'd0);

        // Thirty words back-to-back, ten idle cycles, then thirty reads.
        for (int i = 1; i <= 30; i++) applyStimulus(1, 0, 8'(i));
        applyStimulus(0, 0, 8'h00);
        checkOutput("first_word_visible", {24'd0, rdata}, 32'd1);
        repeat (9) applyStimulus(0, 0, 8'h00);
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(0, 1, 8'h00);
            checkOutput("seq_data", {24'd0, rdata}, i);
        end
        applyStimulus(0, 0, 8'h00);
        checkOutput("seq_empty", {31'd0, rempty}, 32'd1);

        // 1025 writes: full after the 1024th, last one dropped.
        for (int i = 1; i <= 1025; i++) begin
            applyStimulus(1, 0, 8'(i));
            if (i == 1024) checkOutput("fill_not_full", {31'd0, wfull}, 32'd0);
            if (i == 1025) checkOutput("fill_full", {31'd0, wfull}, 32'd1);
        end
        applyStimulus(0, 0, 8'h00);
        checkOutput("overflow_full", {31'd0, wfull}, 32'd1);
        checkOutput("overflow_head", {24'd0, rdata}, 32'd1);
`ifdef ASYNC_FIFO_COUNT_EN
        checkOutput("count_full", {21'd0, count}, 32'd1024);
`endif
        for (int i = 1; i <= 1024; i++) begin
            applyStimulus(0, 1, 8'h00);
            v = i & 32'hFF;
            checkOutput("drain_data", {24'd0, rdata}, v);
        end
        applyStimulus(0, 0, 8'h00);
        checkOutput("drain_empty", {31'd0, rempty}, 32'd1);

        // Reads on an empty FIFO are ignored; a later write shows on the next edge.
        repeat (5) applyStimulus(0, 1, 8'h00);
        applyStimulus(1, 0, 8'hA5);
        checkOutput("underflow_rempty", {31'd0, rempty}, 32'd1);
        checkOutput("underflow_rdata", {24'd0, rdata}, 32'd0);
        applyStimulus(0, 0, 8'h00);
        checkOutput("a5_rdata", {24'd0, rdata}, 32'hA5);
        checkOutput("a5_rempty", {31'd0, rempty}, 32'd0);
        applyStimulus(0, 1, 8'h00);
        applyStimulus(0, 0, 8'h00);
        checkOutput("a5_drained", {31'd0, rempty}, 32'd1);

        // Full FIFO with simultaneous requests: only the read is taken.
        for (int i = 0; i < 1024; i++) applyStimulus(1, 0, 8'(i) ^ 8'h3C);
        applyStimulus(1, 1, 8'hEE);
        checkOutput("simul_pre_full", {31'd0, wfull}, 32'd1);
        checkOutput("simul_pre_head", {24'd0, rdata}, 32'h3C);
        applyStimulus(0, 0, 8'h00);
        checkOutput("simul_post_full", {31'd0, wfull}, 32'd0);
        checkOutput("simul_post_head", {24'd0, rdata}, 32'h3D);

        // Continuous stream at occupancy 1023 wraps both pointers several times.
        for (int k = 0; k < 3000; k++) applyStimulus(1, 1, 8'(k * 7));
        for (int i = 0; i < 1023; i++) applyStimulus(0, 1, 8'h00);
        applyStimulus(0, 0, 8'h00);
        checkOutput("stream_empty", {31'd0, rempty}, 32'd1);

        // Reset mid-stream with twenty words stored.
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 8'(i + 8'h80));
        applyStimulus(0, 0, 8'h00);
        checkOutput("pre_rst_rempty", {31'd0, rempty}, 32'd0);
        checkOutput("pre_rst_head", {24'd0, rdata}, 32'h80);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rempty", {31'd0, rempty}, 32'd1);
        checkOutput("mid_rst_wfull", {31'd0, wfull}, 32'd0);
        checkOutput("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1, 0, 8'h51);
        applyStimulus(1, 0, 8'h52);
        applyStimulus(1, 0, 8'h53);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'h00);
            checkOutput("post_rst_data", {24'd0, rdata}, 32'h51 + i);
        end
        applyStimulus(0, 0, 8'h00);
        checkOutput("post_rst_empty", {31'd0, rempty}, 32'd1);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
